// File: rtl/gt_link_pkg.sv
// gt_link_pkg: definitions shared by the GT receive-link monitor.
//   link_state_e  - link state encoding as seen on link_state (LOS/ACQ/SYNC)
//   K28_5         - byte-0 value of a comma word
//   CTRL_K_BYTE0  - K-flag pattern of a comma word (K char in byte 0 only)
package gt_link_pkg;

  typedef enum logic [1:0] {
    ST_LOS  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2
  } link_state_e;

  localparam logic [7:0] K28_5        = 8'hBC;
  localparam logic [3:0] CTRL_K_BYTE0 = 4'b0001;

endpackage

// File: rtl/gt_sat_counter.sv
// gt_sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset to 0
//   clr  - synchronous clear to 0 (same effect as rst)
//   inc  - count enable
//   cnt  - current count
module gt_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/gt_link_monitor.sv
// gt_link_monitor: passive link-quality monitor on the aligned GT receive stream.
// Classifies each word as comma / invalid (K char outside byte 0) / neutral,
// runs the LOS -> ACQ -> SYNC lock state machine and keeps link statistics.
// Ports:
//   rx_clk        - recovered receive clock, rising edge
//   rst           - synchronous active-high reset
//   gt_rx_data    - aligned receive word, comma always in byte 0
//   gt_rx_ctrl    - K-char flags, bit n for byte n
//   link_up       - high while in SYNC
//   link_state    - 0=LOS, 1=ACQ, 2=SYNC
//   err_cnt       - saturating count of invalid words seen in SYNC
//   link_down_cnt - saturating count of SYNC->LOS transitions
// Build option: define GT_LINK_MON_STATS_EN to implement err_cnt and
// link_down_cnt; otherwise both read as 0 and have no counter registers.
module gt_link_monitor
  import gt_link_pkg::*;
#(
  parameter logic [7:0] COMMA_CHAR    = K28_5,
  parameter int         ACQ_COMMAS    = 4,
  parameter int         COMMA_TIMEOUT = 1024,
  parameter int         ERR_THRESH    = 8,
  parameter int         ERR_WINDOW    = 4096
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic [31:0] gt_rx_data,
  input  logic [3:0]  gt_rx_ctrl,
  output logic        link_up,
  output logic [1:0]  link_state,
  output logic [31:0] err_cnt,
  output logic [15:0] link_down_cnt
);

  localparam logic [7:0]  ACQ_N    = 8'(ACQ_COMMAS);
  localparam logic [7:0]  THRESH_N = 8'(ERR_THRESH);
  localparam logic [15:0] TO_LAST  = 16'(COMMA_TIMEOUT - 1);
  localparam logic [15:0] WIN_LAST = 16'(ERR_WINDOW - 1);

  link_state_e state_q;
  logic [7:0]  comma_cnt_q;
  logic [7:0]  win_err_q;
  logic [15:0] win_tmr_q;
  logic [15:0] to_tmr;

  logic comma;
  logic invalid;
  logic timeout;
  logic wrap;
  logic thresh_hit;
  logic enter_sync;
  logic leave_sync;
  logic unused_data;

  // Word classification on the current input word
  assign comma       = (gt_rx_ctrl == CTRL_K_BYTE0) && (gt_rx_data[7:0] == COMMA_CHAR);
  assign invalid     = |gt_rx_ctrl[3:1];
  assign unused_data = ^gt_rx_data[31:8];

  assign timeout    = (to_tmr == TO_LAST) && !comma;
  assign wrap       = (win_tmr_q == WIN_LAST);
  // Threshold is judged on the count the current window already holds, so a
  // hit on the wrap cycle still takes the link down.
  assign thresh_hit = invalid && ((win_err_q + 8'd1) == THRESH_N);
  // A comma implies neither invalid nor timeout, so ACQ needs no extra gating.
  assign enter_sync = comma &&
                      (((state_q == ST_LOS) && (ACQ_N == 8'd1)) ||
                       ((state_q == ST_ACQ) && ((comma_cnt_q + 8'd1) == ACQ_N)));
  assign leave_sync = (state_q == ST_SYNC) && (thresh_hit || timeout);

  gt_sat_counter #(.W(16)) u_to_tmr (
    .clk (rx_clk),
    .rst (rst),
    .clr (comma || enter_sync),
    .inc (1'b1),
    .cnt (to_tmr)
  );

  // State register stage: state, link_up and window bookkeeping
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q     <= ST_LOS;
      link_up     <= 1'b0;
      comma_cnt_q <= '0;
      win_tmr_q   <= '0;
      win_err_q   <= '0;
    end else begin
      case (state_q)
        ST_LOS: begin
          if (comma) begin
            comma_cnt_q <= 8'd1;
            state_q     <= enter_sync ? ST_SYNC : ST_ACQ;
            link_up     <= enter_sync;
          end
        end
        ST_ACQ: begin
          if (invalid || timeout) begin
            state_q     <= ST_LOS;
            comma_cnt_q <= '0;
          end else if (comma) begin
            comma_cnt_q <= comma_cnt_q + 8'd1;
            if (enter_sync) begin
              state_q <= ST_SYNC;
              link_up <= 1'b1;
            end
          end
        end
        ST_SYNC: begin
          // Window timer and error count sit at 0 outside SYNC, which is
          // what makes SYNC entry start a fresh window.
          if (leave_sync) begin
            state_q     <= ST_LOS;
            link_up     <= 1'b0;
            comma_cnt_q <= '0;
            win_tmr_q   <= '0;
            win_err_q   <= '0;
          end else begin
            win_tmr_q <= wrap ? 16'd0 : win_tmr_q + 16'd1;
            if (wrap) begin
              win_err_q <= invalid ? 8'd1 : 8'd0;
            end else if (invalid) begin
              win_err_q <= win_err_q + 8'd1;
            end
          end
        end
        default: begin
          state_q     <= ST_LOS;
          link_up     <= 1'b0;
          comma_cnt_q <= '0;
          win_tmr_q   <= '0;
          win_err_q   <= '0;
        end
      endcase
    end
  end

  assign link_state = state_q;

  // Statistics stage
`ifdef GT_LINK_MON_STATS_EN
  gt_sat_counter #(.W(32)) u_err_cnt (
    .clk (rx_clk),
    .rst (rst),
    .clr (1'b0),
    .inc ((state_q == ST_SYNC) && invalid),
    .cnt (err_cnt)
  );

  gt_sat_counter #(.W(16)) u_link_down_cnt (
    .clk (rx_clk),
    .rst (rst),
    .clr (1'b0),
    .inc (leave_sync),
    .cnt (link_down_cnt)
  );
`else
  assign err_cnt       = '0;
  assign link_down_cnt = '0;
`endif

endmodule
